move_pulse_gen: RTL

- Front end for the cursor-movement path.
- Takes four raw, bouncing, active-low push-button inputs; synchronises and debounces them.
- Emits single-cycle active-low move pulses in the same 4-bit encoding the cursor block consumes, with auto-repeat while a button is held.
- Sits between the board's button pins and the cursor-position logic.

---
 rtl/move_pulse_gen_pkg.sv | 31 +++
 rtl/move_pulse_gen_btn_repeat.sv | 105 ++++++++++
 rtl/move_pulse_gen.sv | 67 ++++++
 3 files changed

// File: rtl/move_pulse_gen_pkg.sv
// Shared encoding for the cursor-movement path.
// Holds the move-bit indices and the idle value used on the active-low move bus.
// It also holds the cursor field limits, so the pulse generator (producer) and
// the cursor block (consumer) share a single definition.
package move_pulse_gen_pkg;

  // Bit positions on btn_n / move / pressed
  localparam int unsigned MOVE_XDEC = 0;
  localparam int unsigned MOVE_YINC = 1;
  localparam int unsigned MOVE_YDEC = 2;
  localparam int unsigned MOVE_XINC = 3;

  // Active-low bus: all ones means no movement
  localparam logic [3:0] MOVE_IDLE = 4'b1111;

  // Cursor field limits consumed by the cursor-position block
  localparam int unsigned MAX_X = 639;
  localparam int unsigned MAX_Y = 479;

  // Per-button auto-repeat state
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD_DELAY,
    ST_REPEAT
  } rep_state_t;

  function automatic logic [23:0] max24(input logic [23:0] a, input logic [23:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/move_pulse_gen_btn_repeat.sv
// One button channel: 2-flop synchroniser, debouncer and auto-repeat FSM.
// Ports:
//   clk, rst  - system clock, asynchronous active-low reset
//   btn_n     - raw active-low button, asynchronous to clk
//   en        - when low the FSM is held in IDLE with its timer cleared
//   level     - debounced level, active-high (1 = pressed)
//   req       - one-cycle request for a move pulse (press or repeat)
module move_pulse_gen_btn_repeat
  import move_pulse_gen_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd1500000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic en,
  output logic level,
  output logic req
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TW = $clog2(max24(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 16'd1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 24'd1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 24'd1);

  logic [1:0]    sync;
  logic          sync_press;
  logic [DW-1:0] db_cnt;
  logic [TW-1:0] timer;
  rep_state_t    state;

  // Preset to released so reset never looks like a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '1;
    else      sync <= {sync[0], btn_n};
  end

  assign sync_press = ~sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync_press == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      level  <= sync_press;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      timer <= '0;
      req   <= 1'b0;
    end else begin
      req <= 1'b0;
      if (!en || !level) begin
        state <= ST_IDLE;
        timer <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            req   <= 1'b1;
            state <= ST_HOLD_DELAY;
            timer <= '0;
          end
          ST_HOLD_DELAY: begin
            // Without auto-repeat the timer parks at terminal count
            if (timer == DELAY_LAST) begin
              if (REPEAT_EN) begin
                req   <= 1'b1;
                state <= ST_REPEAT;
                timer <= '0;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (timer == PERIOD_LAST) begin
              req   <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/move_pulse_gen.sv
// Button front end for the cursor-movement path.
// Ports:
//   clk, rst - system clock, asynchronous active-low reset
//   btn_n    - raw active-low buttons (bit0 x-1, bit1 y+1, bit2 y-1, bit3 x+1)
//   en       - active-high pulse enable
//   move     - registered one-cycle active-low move pulses, idle 4'b1111
//   pressed  - registered debounced button levels, active-high
module move_pulse_gen
  import move_pulse_gen_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd1500000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  input  logic       en,
  output logic [3:0] move,
  output logic [3:0] pressed
);

  logic [3:0] level;
  logic [3:0] req;
  logic [3:0] req_masked;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    move_pulse_gen_btn_repeat #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_EN)
    ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_n[i]),
      .en    (en),
      .level (level[i]),
      .req   (req[i])
    );
  end

  // Opposing directions cancel; the FSMs keep their timing underneath
  always_comb begin
    req_masked = req;
    if (level[MOVE_XDEC] && level[MOVE_XINC]) begin
      req_masked[MOVE_XDEC] = 1'b0;
      req_masked[MOVE_XINC] = 1'b0;
    end
    if (level[MOVE_YINC] && level[MOVE_YDEC]) begin
      req_masked[MOVE_YINC] = 1'b0;
      req_masked[MOVE_YDEC] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move    <= MOVE_IDLE;
      pressed <= '0;
    end else begin
      move    <= en ? ~req_masked : MOVE_IDLE;
      pressed <= level;
    end
  end

endmodule
